rgb_status_scheduler: RTL and testbench
=======================================

# rgb_status_scheduler

Status-indicator controller for the transmitter board's RGB LED. It arbitrates between three status requesters (error, stream activity, I2S lock) and sequences the LED accordingly. Behaviours are a fade in idle/lock, a timed white flash on activity, and a red blink on error. It generates the three PWM pin drives directly from the 12 MHz board clock, and replaces the free-running colour cycler on the LED pins.

## Interface
- TICK_DIV, 12000: clocks per scheduler tick (1 kHz at 12 MHz); legal range 2..65535.
- ACT_TICKS, 50: activity flash length in ticks; legal range 1..255.
- BLINK_TICKS, 250: error blink half-period in ticks; legal range 1..255.
- IDLE_BLUE, 32: idle blue duty, 8 bit.
- pin_clk_12mhz  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- err_req  in  1  level; error present.
- lock  in  1  level; I2S input locked.
- act_pulse  in  1  single-cycle pulse per transmitted block.
- red  out  1  PWM drive, active-high.
- green  out  1  PWM drive, active-high.
- blue  out  1  PWM drive, active-high.
- state  out  2  current state: IDLE=0, LOCKED=1, ACT=2, ERROR=3.

## Operation
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is high for exactly one clock when the count equals TICK_DIV-1.
- PWM: 8-bit `pwm_cnt` increments every clock and wraps 255->0.
  - Each channel output is registered as (pwm_cnt < duty_x), so duty 0 is always off and duty 255 is high 255 of every 256 clocks.
- Targets per state (r,g,b):
  - IDLE = (0,0,IDLE_BLUE).
  - LOCKED = (0,255,0).
  - ACT = (255,255,255).
  - ERROR = (255,0,0) in the on phase, (0,0,0) in the off phase.
- Duty update:
  - In IDLE or LOCKED, on each tick every duty moves by 1 toward its target. A duty already equal to its target holds.
  - In ACT or ERROR, duty is loaded with the target on every clock, with no fading.
- Transitions are evaluated every clock, priority highest first:
  1. err_req=1 from any state -> ERROR. On entry the blink phase is set to on and the blink counter is cleared.
  2. act_pulse=1 and not in ERROR -> ACT, with act_cnt loaded to ACT_TICKS. A pulse while already in ACT reloads act_cnt (retrigger).
  3. ERROR with err_req=0 -> LOCKED if lock=1, else IDLE.
  4. ACT: on a tick with act_cnt==1, leave -> LOCKED if lock=1, else IDLE. Otherwise act_cnt decrements on each tick.
  5. IDLE -> LOCKED when lock=1; LOCKED -> IDLE when lock=0.
- ERROR blink: the blink counter increments each tick. On a tick with counter==BLINK_TICKS-1, the phase toggles and the counter clears.
- An act_pulse arriving in the same clock as err_req=1 is discarded; no flash follows the error.
- Leaving ACT or ERROR into IDLE/LOCKED starts from the duties then present and fades from there.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state=IDLE, all duties 0, red=green=blue=0.
  - pwm_cnt=0, prescaler=0, act_cnt=0, blink counter=0, blink phase=on.
- The state register updates on the clock edge that samples the request, so state is visible 1 clock after the input.
- Direct-load duties (ACT/ERROR) update 1 clock after the state change. Pin outputs update 1 further clock later, so pins reflect a new duty at latest 2 clocks + one PWM period (256 clocks) after the request.
- After reset release, blue duty reaches IDLE_BLUE after IDLE_BLUE ticks (32 ms at defaults).
- A full fade 0->255 takes 255 ticks.
- PWM period is 256 clocks (21.33 us); the prescaler is independent of pwm_cnt.
- Reset asserted mid-flash or mid-blink aborts immediately with no residual state.
- Inputs are synchronous to pin_clk_12mhz; the block contains no synchronisers.

## Test plan
All scenarios run with TICK_DIV=4, ACT_TICKS=3, BLINK_TICKS=2, IDLE_BLUE=4.
- Reset release, all inputs 0 -> state=0, red=green=0 throughout; blue duty steps 0..4 over 4 ticks; blue high 4 of every 256 clocks thereafter.
- lock=1 held -> state=1 next clock; green duty rises 1 per tick to 255 and blue falls to 0; after 255 ticks green is high 255/256 clocks.
- act_pulse single cycle in LOCKED -> state=2 next clock and all duties 255. state returns to 1 on the 3rd tick. A second pulse after 2 ticks extends ACT to 5 ticks total.
- err_req=1 and act_pulse=1 in the same clock -> state=3, red duty 255, no ACT afterwards. Red toggles 255/0 every 2 ticks. Dropping err_req with lock=0 -> state=0.
- rst_n pulsed low during ACT -> outputs 0 asynchronously (before the next clock edge), state=0, act_cnt=0.
- Random mix of lock/err_req/act_pulse over 20k clocks -> state never 2 while err_req=1. Each pin's on-count per 256-clock window equals the duty at the window start, when the duty is stable over the window.

Source files
------------

// File: rtl/rgb_status_scheduler.sv
// rgb_status_scheduler: arbitrates error/activity/lock status onto the RGB LED,
// fading in idle/lock, flashing white on activity, blinking red on error.
module rgb_status_scheduler #(
  parameter int TICK_DIV    = 12000,
  parameter int ACT_TICKS   = 50,
  parameter int BLINK_TICKS = 250,
  parameter int IDLE_BLUE   = 32
) (
  input  logic       pin_clk_12mhz,
  input  logic       rst_n,
  input  logic       err_req,
  input  logic       lock,
  input  logic       act_pulse,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE, LOCKED, ACT, ERROR} state_t;
  state_t cur, nxt, settle;
  logic [15:0] pre_cnt;
  logic [7:0] pwm_cnt, act_cnt, blink_cnt;
  logic [7:0] duty_r, duty_g, duty_b, tgt_r, tgt_g, tgt_b;
  logic tick, phase, act_load, err_entry;
  function automatic logic [7:0] fade(input logic [7:0] d, input logic [7:0] t);
    return d < t ? d + 8'd1 : d > t ? d - 8'd1 : d;
  endfunction
  assign state     = cur;
  assign tick      = pre_cnt == 16'(TICK_DIV - 1);
  assign settle    = lock ? LOCKED : IDLE;
  assign err_entry = err_req && cur != ERROR;
  assign act_load  = !err_req && act_pulse && cur != ERROR;
  always_ff @(posedge pin_clk_12mhz or negedge rst_n)
    if (!rst_n) cur <= IDLE;
    else cur <= nxt;
  always_comb begin
    nxt = err_req ? ERROR :
          act_load ? ACT :
          cur == ACT ? ((tick && act_cnt == 8'd1) ? settle : ACT) :
          settle;
  end
  always_comb begin
    tgt_r = (cur == ACT || (cur == ERROR && phase)) ? 8'hff : 8'h00;
    tgt_g = (cur == ACT || cur == LOCKED) ? 8'hff : 8'h00;
    tgt_b = cur == ACT ? 8'hff : cur == IDLE ? 8'(IDLE_BLUE) : 8'h00;
  end
  always_ff @(posedge pin_clk_12mhz or negedge rst_n)
    if (!rst_n) begin
      pre_cnt   <= '0;
      pwm_cnt   <= '0;
      act_cnt   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      duty_r    <= '0;
      duty_g    <= '0;
      duty_b    <= '0;
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
      pwm_cnt <= pwm_cnt + 8'd1;
      red     <= pwm_cnt < duty_r;
      green   <= pwm_cnt < duty_g;
      blue    <= pwm_cnt < duty_b;
      // ACT/ERROR snap to target; IDLE/LOCKED fade one step per tick
      if (cur == ACT || cur == ERROR) begin
        duty_r <= tgt_r;
        duty_g <= tgt_g;
        duty_b <= tgt_b;
      end else if (tick) begin
        duty_r <= fade(duty_r, tgt_r);
        duty_g <= fade(duty_g, tgt_g);
        duty_b <= fade(duty_b, tgt_b);
      end
      if (act_load) act_cnt <= 8'(ACT_TICKS);
      else if (cur == ACT && tick) act_cnt <= act_cnt - 8'd1;
      if (err_entry) begin
        phase     <= 1'b1;
        blink_cnt <= '0;
      end else if (cur == ERROR && tick) begin
        phase     <= blink_cnt == 8'(BLINK_TICKS - 1) ? ~phase : phase;
        blink_cnt <= blink_cnt == 8'(BLINK_TICKS - 1) ? 8'd0 : blink_cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_rgb_status_scheduler.sv
// tb_rgb_status_scheduler: cycle model feeding a scoreboard, a table of state
// vectors, and hand sequences for timing, PWM windows, blink and async reset.
module tb_rgb_status_scheduler;
  localparam int TD = 4, AT = 3, BT = 2, IB = 4;
  logic clk = 0, rst_n = 0, err_req = 0, lock = 0, act_pulse = 0;
  logic red, green, blue;
  logic [1:0] state;
  int total = 0, bad = 0;

  rgb_status_scheduler #(.TICK_DIV(TD), .ACT_TICKS(AT), .BLINK_TICKS(BT), .IDLE_BLUE(IB)) dut (
    .pin_clk_12mhz(clk), .rst_n(rst_n), .err_req(err_req), .lock(lock), .act_pulse(act_pulse),
    .red(red), .green(green), .blue(blue), .state(state));

  always #5 clk = ~clk;

  typedef struct {int st, pre, pwm, act, bc, ph, dr, dg, db, r, g, b;} mdl_t;
  typedef struct {int e, l, a, n, st;} vec_t;
  mdl_t m;
  logic [4:0] exp_q[$];

  vec_t vt[16] = '{
    '{0,0,0,1,0}, '{0,1,0,1,1}, '{0,1,1,1,2}, '{0,1,0,1,2},
    '{1,1,1,1,3}, '{1,1,0,5,3}, '{0,0,0,1,0}, '{0,0,0,3,0},
    '{0,0,1,1,2}, '{0,0,0,20,0}, '{0,1,0,1,1}, '{1,1,0,1,3},
    '{0,1,0,1,1}, '{0,1,1,1,2}, '{1,1,0,1,3}, '{0,1,0,20,1}};

  function automatic mdl_t mreset();
    mdl_t z;
    z = '{default: 0};
    z.ph = 1;
    return z;
  endfunction

  function automatic int toward(int d, int t);
    return d < t ? d + 1 : d > t ? d - 1 : d;
  endfunction

  function automatic mdl_t mstep(mdl_t c, logic e, logic l, logic a);
    mdl_t n = c;
    bit tk = c.pre == TD - 1;
    int tr, tg, tb;
    n.pre = tk ? 0 : c.pre + 1;
    n.pwm = (c.pwm + 1) % 256;
    n.r = int'(c.pwm < c.dr);
    n.g = int'(c.pwm < c.dg);
    n.b = int'(c.pwm < c.db);
    case (c.st)
      0: begin tr = 0; tg = 0; tb = IB; end
      1: begin tr = 0; tg = 255; tb = 0; end
      2: begin tr = 255; tg = 255; tb = 255; end
      default: begin tr = c.ph ? 255 : 0; tg = 0; tb = 0; end
    endcase
    if (c.st >= 2) begin
      n.dr = tr; n.dg = tg; n.db = tb;
    end else if (tk) begin
      n.dr = toward(c.dr, tr); n.dg = toward(c.dg, tg); n.db = toward(c.db, tb);
    end
    if (c.st == 3 && tk) begin
      if (c.bc == BT - 1) begin n.bc = 0; n.ph = 1 - c.ph; end
      else n.bc = c.bc + 1;
    end
    if (e) begin
      n.st = 3;
      if (c.st != 3) begin n.ph = 1; n.bc = 0; end
    end else if (a && c.st != 3) begin
      n.st = 2; n.act = AT;
    end else if (c.st == 3) n.st = l ? 1 : 0;
    else if (c.st == 2) begin
      if (tk) begin
        if (c.act == 1) n.st = l ? 1 : 0;
        n.act = c.act - 1;
      end
    end else n.st = l ? 1 : 0;
    return n;
  endfunction

  initial begin
    m = mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m = mreset();
        exp_q.delete();
      end else begin
        m = mstep(m, err_req, lock, act_pulse);
        exp_q.push_back({2'(m.st), 1'(m.r), 1'(m.g), 1'(m.b)});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && exp_q.size() > 0) begin
      total++;
      if ({state, red, green, blue} !== exp_q[0]) begin
        bad++;
        $display("FAIL scoreboard t=%0t got st/rgb=%b want=%b", $time, {state, red, green, blue}, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  end

  task automatic chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic set(int e, int l, int a);
    err_req = 1'(e); lock = 1'(l); act_pulse = 1'(a);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic window(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (256) begin
      @(negedge clk);
      r += int'(red); g += int'(green); b += int'(blue);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r, g, b, cnt, pe;
    repeat (3) begin
      @(negedge clk);
      chk("rst_state", int'(state), 0);
      chk("rst_pins", int'({red, green, blue}), 0);
    end
    rst_n = 1;
    cyc(40);
    window(r, g, b);
    chk("idle_red_on", r, 0);
    chk("idle_green_on", g, 0);
    chk("idle_blue_on", b, IB);
    set(0, 1, 0);
    cyc(1);
    chk("lock_state", int'(state), 1);
    cyc(4 * 256 + 20);
    window(r, g, b);
    chk("lock_green_on", g, 255);
    chk("lock_blue_on", b, 0);
    chk("lock_red_on", r, 0);
    foreach (vt[i]) begin
      set(vt[i].e, vt[i].l, vt[i].a);
      cyc(vt[i].n);
      chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
    end
    set(0, 1, 1);
    cyc(1);
    cnt = int'(state == 2);
    set(0, 1, 0);
    repeat (39) begin cyc(1); cnt += int'(state == 2); end
    chk("act_len_9to12", int'(cnt >= 9 && cnt <= 12), 1);
    set(0, 1, 1);
    cyc(1);
    cnt = int'(state == 2);
    set(0, 1, 0);
    repeat (7) begin cyc(1); cnt += int'(state == 2); end
    set(0, 1, 1);
    cyc(1);
    cnt += int'(state == 2);
    set(0, 1, 0);
    repeat (40) begin cyc(1); cnt += int'(state == 2); end
    chk("retrig_len_17to20", int'(cnt >= 17 && cnt <= 20), 1);
    set(1, 0, 0);
    cnt = 0;
    repeat (64) begin cyc(1); cnt += int'(red); end
    chk("err_state", int'(state), 3);
    chk("blink_red_half", int'(cnt >= 24 && cnt <= 40), 1);
    set(0, 0, 0);
    cyc(1);
    chk("err_drop_idle", int'(state), 0);
    set(0, 0, 1);
    cyc(1);
    set(0, 0, 0);
    cyc(3);
    chk("pre_rst_act", int'(state), 2);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pins", int'({red, green, blue}), 0);
    chk("async_rst_state", int'(state), 0);
    @(negedge clk);
    rst_n = 1;
    cyc(20);
    chk("post_rst_idle", int'(state), 0);
    pe = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(63) == 0) pe = 1 - pe;
      if ($urandom_range(127) == 0) lock = ~lock;
      err_req = 1'(pe);
      act_pulse = $urandom_range(15) == 0;
      cyc(1);
      if (pe == 1) chk("err_blocks_act", int'(state), 3);
    end
    set(0, 0, 0);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
